ir_regsel: RTL
==============

// Module: ir_regsel
// PURPOSE
//  Instruction register and register-address stage directly upstream of the register file on the shared 32-bit bus.
//  - Loads the fetched instruction from the bus and decodes rs1/rs2/rd.
//  - Drives the register file's 6-bit addr; 32 selects PC.
//  - Builds the sign-extended immediate and drives it onto the bus when the microcode asks for it.
// PARAMETERS
//  DATA_WIDTH  32  bus / instruction width
//  ADDR_WIDTH  6   register-file address width (0..31 GPR, 32 = PC)
//  PC_ADDR     32  address placed on addr when regSel selects PC
// PORTS
//  clock     in     1   single system clock, all state updates on posedge
//  reset     in     1   synchronous, active-high
//  data      inout  32  shared bus; IR source, immediate destination
//  ldIR      in     1   microcode: latch bus into IR this edge
//  enImm     in     1   microcode: drive immediate onto bus
//  immSel    in     3   0=I 1=S 2=B 3=U 4=J; 5..7 reserved -> immediate 0
//  regSel    in     2   0=rs1 1=rs2 2=rd 3=PC
//  addr      out    6   register-file address
//  irReady   out    1   IR decoded, immediate valid
//  opcode    out    7   IR[6:0]
//  funct3    out    3   IR[14:12]
//  funct7b5  out    1   IR[30]
//  immErr    out    1   sticky: enImm seen while not READY
// BEHAVIOUR
//  Reset values (synchronous, on edge with reset=1):
//  - IR=32'h0000_0013 (NOP); immReg=0; state=EMPTY; irReady=0; immErr=0.
//  - Reset wins over ldIR on the same edge.
//  FSM, one transition per edge:
//  - EMPTY -> LOADED on ldIR.
//  - LOADED -> READY unconditionally; immReg <= imm(IR, immSel) this edge.
//  - READY -> LOADED on ldIR.
//  - ldIR in LOADED: re-latch IR, stay in LOADED.
//  - immReg recomputes every edge in READY, so a changed immSel shows up 1 cycle later.
//  Latency and outputs:
//  - ldIR at edge N -> irReady=1 after edge N+1; immediate usable from cycle N+2.
//  - irReady = (state==READY), registered.
//  - opcode/funct3/funct7b5 come combinationally from IR.
//  addr (combinational):
//  - regSel=3 -> PC_ADDR in any state.
//  - Otherwise IR[19:15] / IR[24:20] / IR[11:7], zero-extended to 6 bits.
//  - In EMPTY, GPR selects give 0.
//  Immediate: RV32I formats, sign bit IR[31]. B and J immediates have bit0=0. U immediate = {IR[31:12],12'b0}.
//  Bus drive: data = (enImm & ~ldIR & state==READY) ? immReg : 'z.
//  - Never drives while ldIR=1.
//  - ldIR and enImm together: the load from the other driver wins; no drive from this block.
//  - enImm in EMPTY or LOADED: bus stays Z and immErr sets. It clears only on reset.
// CONFIGURATION
//  IRSEL_ILLEGAL_CHECK_EN
//  - Defined: adds output illegal (1 bit, reset 0), registered on the LOADED->READY edge.
//    Set to 1 when opcode is not one of 03,13,17,23,33,37,63,67,6F,73 (hex).
//  - In READY with illegal=1, the bus is still not driven, and immErr sets if enImm is asserted.
//  - Undefined: the port and its logic are absent; every opcode is treated as legal.
// STRUCTURE
//  Package riscv_pkg:
//  - OPC_* opcode constants
//  - IMM_I..IMM_J immSel encodings
//  - SEL_RS1/SEL_RS2/SEL_RD/SEL_PC
//  - state encoding S_EMPTY/S_LOADED/S_READY
//  - NOP_INSTR
//  Sub-module imm_gen: purely combinational (ir, immSel) -> imm. The FSM, IR, immReg and tristate stay in ir_regsel.
// TESTING
//  1. reset, then ldIR with data=32'h00A30293 (addi x5,x6,10), immSel=0 -> after 2 edges irReady=1, opcode=7'h13.
//     enImm=1 -> data=32'h0000000A.
//  2. IR=32'hFE000EE3 (beq, imm -4), immSel=2, enImm -> data=32'hFFFFFFFC. regSel=0 -> addr=0; regSel=1 -> addr=0.
//  3. IR=32'h00A30293: regSel 0/1/2/3 -> addr 6/10/5/32. Before any load, regSel=2 -> addr=0.
//  4. enImm on the cycle right after ldIR -> data stays Z, immErr=1; immErr still 1 after a further ldIR; reset clears it.
//  5. ldIR and enImm same cycle with data=32'h12345037 driven externally -> no contention on the bus, IR=32'h12345037.
//     Two cycles later, U immediate = 32'h12345000.
//  6. With IRSEL_ILLEGAL_CHECK_EN: load 32'hFFFFFFFF -> illegal=1 once READY; enImm -> bus Z, immErr=1.

Source files
------------

// File: rtl/ir_regsel_pkg.sv
// riscv_pkg: opcode, immediate-format, register-select and state encodings
// shared by the IR / register-select stage and its bench.
package riscv_pkg;
   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 6;
   localparam logic [ADDR_WIDTH-1:0] PC_ADDR = 6'd32;
   localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_OPIMM  = 7'h13;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_SYSTEM = 7'h73;
   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;
   localparam logic [1:0] SEL_RS1 = 2'd0;
   localparam logic [1:0] SEL_RS2 = 2'd1;
   localparam logic [1:0] SEL_RD  = 2'd2;
   localparam logic [1:0] SEL_PC  = 2'd3;
   typedef enum logic [1:0] {S_EMPTY, S_LOADED, S_READY} state_t;
   function automatic logic opc_legal(input logic [6:0] opc);
      return opc inside {OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP,
                         OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM};
   endfunction
endpackage

// File: rtl/ir_regsel_if.sv
// ir_regsel_if: microcode controls and decode outputs of the IR stage.
interface ir_regsel_if;
   import riscv_pkg::*;
   logic                  ldIR;
   logic                  enImm;
   logic [2:0]            immSel;
   logic [1:0]            regSel;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  irReady;
   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic                  funct7b5;
   logic                  immErr;
`ifdef IRSEL_ILLEGAL_CHECK_EN
   logic                  illegal;
   modport slave (input ldIR, enImm, immSel, regSel,
                  output addr, irReady, opcode, funct3, funct7b5, immErr, illegal);
   modport master (output ldIR, enImm, immSel, regSel,
                   input addr, irReady, opcode, funct3, funct7b5, immErr, illegal);
`else
   modport slave (input ldIR, enImm, immSel, regSel,
                  output addr, irReady, opcode, funct3, funct7b5, immErr);
   modport master (output ldIR, enImm, immSel, regSel,
                   input addr, irReady, opcode, funct3, funct7b5, immErr);
`endif
endinterface

// File: rtl/ir_regsel_imm_gen.sv
// imm_gen: RV32I immediate builder; opcode bits are not needed so only IR[31:7] enters.
module imm_gen
   import riscv_pkg::*;
(
   input  logic [31:7]           ir_i,
   input  logic [2:0]            imm_sel_i,
   output logic [DATA_WIDTH-1:0] imm_o
);
   always_comb
      imm_o = imm_sel_i == IMM_I ? {{20{ir_i[31]}}, ir_i[31:20]} :
              imm_sel_i == IMM_S ? {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]} :
              imm_sel_i == IMM_B ? {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0} :
              imm_sel_i == IMM_U ? {ir_i[31:12], 12'b0} :
              imm_sel_i == IMM_J ? {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0} :
              '0;
endmodule

// File: rtl/ir_regsel.sv
// ir_regsel: instruction register, register-file address select and immediate bus driver.
// Optional IRSEL_ILLEGAL_CHECK_EN adds an illegal-opcode flag that also blocks the immediate drive.
module ir_regsel
   import riscv_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   inout  wire  [DATA_WIDTH-1:0] data,
   ir_regsel_if.slave            bus
);
   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] ir_q, imm_q, imm_d;
   logic                  err_q, ill, drive;
   imm_gen u_imm_gen (.ir_i(ir_q[31:7]), .imm_sel_i(bus.immSel), .imm_o(imm_d));
   // ldIR always wins, so a re-load from LOADED simply stays in LOADED
   assign state_d = bus.ldIR ? S_LOADED : state_q == S_LOADED ? S_READY : state_q;
   always_ff @(posedge clock) begin
      if (reset) begin
         ir_q    <= NOP_INSTR;
         imm_q   <= '0;
         state_q <= S_EMPTY;
         err_q   <= 1'b0;
      end else begin
         if (bus.ldIR) ir_q <= data;
         if (state_q != S_EMPTY) imm_q <= imm_d;
         state_q <= state_d;
         err_q   <= err_q | (bus.enImm & (state_q != S_READY | ill));
      end
   end
`ifdef IRSEL_ILLEGAL_CHECK_EN
   logic ill_q;
   always_ff @(posedge clock) begin
      if (reset) ill_q <= 1'b0;
      else if (state_q == S_LOADED && !bus.ldIR) ill_q <= !opc_legal(ir_q[6:0]);
   end
   assign ill         = ill_q;
   assign bus.illegal = ill_q;
`else
   assign ill = 1'b0;
`endif
   assign drive        = bus.enImm & ~bus.ldIR & (state_q == S_READY) & ~ill;
   assign data         = drive ? imm_q : 'z;
   assign bus.irReady  = state_q == S_READY;
   assign bus.immErr   = err_q;
   assign bus.opcode   = ir_q[6:0];
   assign bus.funct3   = ir_q[14:12];
   assign bus.funct7b5 = ir_q[30];
   always_comb
      bus.addr = bus.regSel == SEL_PC ? PC_ADDR :
                 state_q == S_EMPTY   ? '0 :
                 {1'b0, bus.regSel == SEL_RS1 ? ir_q[19:15] :
                        bus.regSel == SEL_RS2 ? ir_q[24:20] : ir_q[11:7]};
endmodule
